// File: rtl/sfx_pkg.sv
// Shared types, FSM states and the effect note ROM for the sound-effect sequencer.
package sfx_pkg;

  localparam int MAX_NOTES    = 8;
  localparam int NOTE_W       = 3;
  localparam int NUM_EFFECTS  = 4;
  localparam int ROM_PERIOD_W = 16;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

  typedef struct packed {
    logic [ROM_PERIOD_W-1:0] period;
    logic [7:0]              dur;
    logic                    last;
  } note_t;

  localparam note_t S = '{period: 16'd0, dur: 8'd1, last: 1'b1};

  // Rows: 0 crash, 1 pickup, 2 fuel-low, 3 fixed test pattern.
  localparam note_t NOTE_ROM [NUM_EFFECTS][MAX_NOTES] = '{
    '{'{16'd5, 8'd1, 1'b0}, '{16'd0, 8'd0, 1'b0}, '{16'd4, 8'd1, 1'b1}, S, S, S, S, S},
    '{'{16'd2, 8'd1, 1'b0}, '{16'd1, 8'd2, 1'b0}, '{16'd3, 8'd1, 1'b1}, S, S, S, S, S},
    '{'{16'd6, 8'd1, 1'b0}, '{16'd7, 8'd1, 1'b1}, S, S, S, S, S, S},
    '{'{16'd3, 8'd2, 1'b0}, '{16'd0, 8'd1, 1'b0}, '{16'd2, 8'd1, 1'b1}, S, S, S, S, S}
  };

  function automatic note_t get_note(input int unsigned id, input int unsigned idx);
    logic [1:0]        e;
    logic [NOTE_W-1:0] n;
    e = id[1:0];
    n = idx[NOTE_W-1:0];
    return (id < NUM_EFFECTS && idx < MAX_NOTES) ? NOTE_ROM[e][n] : S;
  endfunction

endpackage

// File: rtl/sfx_sequencer_if.sv
// Request/control and note-output signals between the game logic and the sequencer.
interface sfx_sequencer_if #(parameter int NUM_REQ = 4);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] req;
  logic               mute;
  logic               sample_en;
  logic               play;
  logic               busy;
  logic [ID_W-1:0]    active_id;
  logic               done;

  modport master (output req, mute, input sample_en, play, busy, active_id, done);
  modport slave  (input req, mute, output sample_en, play, busy, active_id, done);

endinterface

// File: rtl/sfx_prio_arb.sv
// Combinational fixed-priority pick: lowest set index of the pending vector wins.
module sfx_prio_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] pending,
  output logic               valid,
  output logic [ID_W-1:0]    idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pending[i] && !valid) begin
        valid = 1'b1;
        idx   = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: arbitrates effect requests and plays each as timed notes,
// generating the sine-table step enable (sample_en) and play enable.
module sfx_sequencer #(
  parameter int NUM_REQ     = 4,
  parameter int DIV_WIDTH   = 16,
  parameter int TICK_CYCLES = 500000
) (
  input logic            clk,
  input logic            resetN,
  sfx_sequencer_if.slave bus
);
  import sfx_pkg::*;

  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  state_t              state, state_nx;
  logic [NUM_REQ-1:0]  pending, clr;
  logic [ID_W-1:0]     active_id, id_nx, arb_idx;
  logic [NOTE_W-1:0]   note_idx, idx_nx;
  logic [DIV_WIDTH-1:0] period, div_cnt;
  logic [TICK_W-1:0]   tick_cnt;
  logic [7:0]          dur_cnt;
  logic                last, done_q, done_nx;
  logic                arb_valid, div_hit, tick, expire, preempt;
  note_t               rom_note;

  sfx_prio_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .pending(pending),
    .valid  (arb_valid),
    .idx    (arb_idx)
  );

  assign rom_note = get_note(32'(active_id), 32'(note_idx));
  assign div_hit  = (div_cnt == period - DIV_WIDTH'(1));
  assign tick     = (tick_cnt == TICK_W'(TICK_CYCLES - 1));
  assign expire   = (state == PLAY) && tick && (dur_cnt == 8'd1);
  assign preempt  = (state == PLAY) && arb_valid && (arb_idx < active_id);

  // Only the LOAD that starts a run (note 0) consumes the request; it beats a same-cycle req.
  assign clr = (state == LOAD && note_idx == '0) ? (NUM_REQ'(1) << active_id) : '0;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    id_nx    = active_id;
    idx_nx   = note_idx;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (arb_valid) begin
          state_nx = LOAD;
          id_nx    = arb_idx;
          idx_nx   = '0;
        end
      end
      LOAD: state_nx = PLAY;
      PLAY: begin
        if (preempt) begin
          state_nx = LOAD;
          id_nx    = arb_idx;
          idx_nx   = '0;
        end else if (expire) begin
          if (last) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else begin
            state_nx = LOAD;
            idx_nx   = note_idx + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pending   <= '0;
      active_id <= '0;
      note_idx  <= '0;
      done_q    <= 1'b0;
      period    <= '0;
      last      <= 1'b0;
      dur_cnt   <= '0;
      div_cnt   <= '0;
      tick_cnt  <= '0;
    end else begin
      pending   <= (pending | bus.req) & ~clr;
      active_id <= id_nx;
      note_idx  <= idx_nx;
      done_q    <= done_nx;
      if (state == LOAD) begin
        period   <= DIV_WIDTH'(rom_note.period);
        last     <= rom_note.last;
        dur_cnt  <= (rom_note.dur == 8'd0) ? 8'd1 : rom_note.dur;
        div_cnt  <= '0;
        tick_cnt <= '0;
      end else if (state == PLAY) begin
        div_cnt  <= div_hit ? '0 : div_cnt + 1'b1;
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        if (tick) dur_cnt <= dur_cnt - 8'd1;
      end
    end
  end

  assign bus.play      = (state == PLAY) && (period != '0) && !bus.mute;
  assign bus.sample_en = bus.play && div_hit;
  assign bus.busy      = (state != IDLE);
  assign bus.active_id = active_id;
  assign bus.done      = done_q;

endmodule

// File: doc/sfx_sequencer.md
# sfx_sequencer

Sound-effect sequencer for the audio path. It arbitrates between game-event sound requests (crash, pickup, fuel-low, …) and plays the chosen effect as a timed series of notes. For each note it generates the step enable (`sample_en`) and the play enable (`play`) for the sine-table address counter. Pitch is set by how often `sample_en` pulses; silence is set by deasserting `play`.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of effect requesters. Index 0 has the highest priority.
- `DIV_WIDTH`, default 16: width of the note period field and of the period divider.
- `TICK_CYCLES`, default 500000: clock cycles per duration tick (10 ms at 50 MHz).

Ports:
- `clk` in 1: system clock. It is the only clock.
- `resetN` in 1: asynchronous, active-low reset.
- `req` in `NUM_REQ`: one-cycle request pulses, one per effect.
- `mute` in 1: silences the output; sequencing continues.
- `sample_en` out 1: one-cycle pulse, one address step. Drives the counter's `en`.
- `play` out 1: high while a note sounds. Drives the counter's `en1`.
- `busy` out 1: high whenever the state is not IDLE.
- `active_id` out `$clog2(NUM_REQ)`: effect currently loaded or playing.
- `done` out 1: one-cycle pulse when an effect finishes its last note.

## Operation
- **Pending register.**
  - A `req[i]` pulse sets `pending[i]`.
  - `pending[i]` clears when effect `i` is latched in LOAD.
  - If `req[i]` arrives in the same cycle that clear happens, the clear wins and the request merges into the run being started.
- **Note ROM.** It is indexed by (effect id, note index). Each entry holds:
  - `period` (`DIV_WIDTH` bits). `period` = 0 is a rest.
  - `dur` in ticks (8 bits). `dur` = 0 is treated as 1.
  - `last` flag.
- **FSM states.**
  - IDLE: if any `pending` bit is set, go to LOAD with the lowest set index. `note_idx` = 0.
  - LOAD, one cycle:
    - Register the ROM entry.
    - Clear the divider and the tick prescaler.
    - Set the duration counter to `dur`.
    - Go to PLAY.
  - PLAY: the period divider and the tick prescaler both run.
    - When the duration counter expires and `last` is 0: increment `note_idx` and go to LOAD.
    - When the duration counter expires and `last` is 1: pulse `done` and go to IDLE.
- **Preemption.** In PLAY, a pending bit with an index lower than `active_id` restarts the sequence:
  - go to LOAD with that id and `note_idx` = 0;
  - `done` is not pulsed for the abandoned effect.

  Equal- or lower-priority requests stay pending.
- **Simultaneous events.** When note expiry and preemption occur in the same cycle, preemption wins.
- **Output rules.**
  - `play` = (state is PLAY) AND (`period` ≠ 0) AND NOT `mute`.
  - `sample_en` pulses only when `play` is high.
  - `mute` does not alter timing, state or `done`.
- **Reset.** Reset is asynchronous and may occur mid-note. Every register clears immediately: state returns to IDLE and all outputs go to 0.

## Timing
- Reset values: `sample_en`, `play`, `busy`, `done` = 0; `active_id` = 0; `pending` = 0.
- Request latency:
  - A `req` pulse at clock edge t sets `pending` at t.
  - The state is LOAD after t+1 and PLAY after t+2.
  - `busy` goes high from t+1.
- Period divider:
  - It counts 0 to `period`−1.
  - `sample_en` pulses on the cycle the count reaches `period`−1, then the count wraps to 0.
  - The first pulse comes `period` cycles after PLAY is entered.
  - `period` = 1 pulses every cycle.
- Note duration: PLAY lasts exactly `dur`×`TICK_CYCLES` cycles, followed by one LOAD cycle between notes. No `sample_en` pulse occurs during LOAD.
- `done` is asserted in the cycle the state returns to IDLE. A pending effect then starts via LOAD on the next edge.

## Structure
- `sfx_pkg` holds:
  - the `note_t` struct (`period`, `dur`, `last`);
  - the state enum (IDLE, LOAD, PLAY);
  - the note ROM as a constant array plus a `get_note(id, idx)` function;
  - `MAX_NOTES` = 8.
- Effect 3 is the fixed test pattern:
  - note 0: period 3, dur 2;
  - note 1: period 0, dur 1;
  - note 2: period 2, dur 1, last.
- Sub-module `sfx_prio_arb`: combinational lowest-index-first pick over `pending`. It outputs a valid flag and an index.
- The divider, prescaler and duration counter are inline counters in `sfx_sequencer`.

## Test plan
All scenarios use `TICK_CYCLES` = 4.
- **Single effect.** Pulse `req[3]`:
  - PLAY 8 cycles with `sample_en` at PLAY cycles 3 and 6;
  - LOAD, then 4 cycles with `play` = 0;
  - LOAD, then 4 cycles with pulses at cycles 2 and 4;
  - `done` pulses once and `busy` falls.
- **Preemption.** During effect 3 note 0, pulse `req[1]`:
  - within 1 cycle the state goes to LOAD with `active_id` = 1 and `note_idx` = 0;
  - no `done` for effect 3.
- **Queued request.** During effect 1, pulse `req[2]`:
  - effect 1 completes and `done` pulses;
  - 1 cycle later LOAD starts effect 2.
- **Simultaneous requests.** Pulse `req[0]` and `req[2]` in the same cycle: effect 0 plays first, then effect 2.
- **Mute.** Hold `mute` = 1 during effect 3: `play` and `sample_en` stay 0, and `done` arrives at the same cycle as in the unmuted run.
- **Reset mid-note.** Assert `resetN` = 0 mid-note and release it: all outputs are 0 during reset, the FSM is IDLE and `pending` = 0.
